// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {FETCH, MISS, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_c;
  } iq_entry_t;

  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] instr);
    return pc + (is_compressed(instr[1:0]) ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/inst_queue.sv
// In-order circular FIFO of fetched instructions; pointers carry an extra wrap bit.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DepthW = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  iq_entry_t entry_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output iq_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int unsigned Depth = 1 << DepthW;
  localparam logic [DepthW:0] PtrOne = {{DepthW{1'b0}}, 1'b1};

  iq_entry_t       mem_q [Depth];
  logic [DepthW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  assign full_o  = (wr_ptr_q[DepthW] != rd_ptr_q[DepthW]) &&
                   (wr_ptr_q[DepthW-1:0] == rd_ptr_q[DepthW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[DepthW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i && !full_o) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[DepthW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/ins_fetcher.sv
// Fetch front end: PC, adapter handshake, instruction queue; the direct-mapped
// I-cache is present only when ICACHE_EN is defined.
module ins_fetcher
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_IDX_W = 6,
  parameter int unsigned IQ_DEPTH_W   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic [31:0] redirect_pc,
  output logic        try_start_insfetch_task,
  output logic [31:0] insfetch_addr,
  input  logic        insfetch_task_done,
  input  logic [31:0] insfetch_ins_full,
  output logic        iq_valid,
  input  logic        iq_ready,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_instr,
  output logic        iq_is_c
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, miss_pc_q, miss_pc_d, new_pc_q, new_pc_d;
  logic         hit;
  logic [31:0]  hit_data;
  logic         q_push, q_pop, q_flush, q_full, q_empty;
  iq_entry_t    q_entry, q_head;

`ifdef ICACHE_EN
  localparam int unsigned Entries = 1 << ICACHE_IDX_W;
  localparam int unsigned TagW    = 31 - ICACHE_IDX_W;

  logic [Entries-1:0]      valid_q;
  logic [TagW-1:0]         tag_q  [Entries];
  logic [31:0]             data_q [Entries];
  logic [ICACHE_IDX_W-1:0] idx, fill_idx;
  logic                    fill;

  assign idx      = pc_q[ICACHE_IDX_W:1];
  assign fill_idx = miss_pc_q[ICACHE_IDX_W:1];
  assign hit      = valid_q[idx] && (tag_q[idx] == pc_q[31:ICACHE_IDX_W+1]);
  assign hit_data = data_q[idx];
  // Fills happen even when the fetch was flushed (DRAIN), so the line is not wasted.
  assign fill     = rdy_in && insfetch_task_done && (state_q != FETCH);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_q[fill_idx]  <= miss_pc_q[31:ICACHE_IDX_W+1];
      data_q[fill_idx] <= insfetch_ins_full;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q      <= RESET_PC;
      miss_pc_q <= '0;
      new_pc_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      miss_pc_q <= miss_pc_d;
      new_pc_q  <= new_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    miss_pc_d     = miss_pc_q;
    new_pc_d      = new_pc_q;
    q_push        = 1'b0;
    q_flush       = 1'b0;
    q_entry.pc    = pc_q;
    q_entry.instr = hit_data;
    q_entry.is_c  = is_compressed(hit_data[1:0]);
    if (rdy_in) begin
      q_flush = flush_pipline;
      if (flush_pipline) new_pc_d = redirect_pc;
      unique case (state_q)
        FETCH: begin
          if (flush_pipline) begin
            pc_d = redirect_pc;
          end else if (!q_full) begin
            if (hit) begin
              q_push = 1'b1;
              pc_d   = next_pc(pc_q, hit_data);
            end else begin
              miss_pc_d = pc_q;
              state_d   = MISS;
            end
          end
        end
        MISS: begin
          q_entry.pc    = miss_pc_q;
          q_entry.instr = insfetch_ins_full;
          q_entry.is_c  = is_compressed(insfetch_ins_full[1:0]);
          if (flush_pipline) begin
            pc_d    = redirect_pc;
            state_d = insfetch_task_done ? FETCH : DRAIN;
          end else if (insfetch_task_done) begin
            q_push  = 1'b1;
            pc_d    = next_pc(miss_pc_q, insfetch_ins_full);
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (insfetch_task_done) begin
            pc_d    = new_pc_d;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign q_pop = rdy_in && !flush_pipline && !q_empty && iq_ready;

  always_comb begin
    try_start_insfetch_task = (state_q != FETCH);
    insfetch_addr           = miss_pc_q;
    iq_valid                = !q_empty;
    iq_pc                   = '0;
    iq_instr                = '0;
    iq_is_c                 = 1'b0;
    if (!q_empty) begin
      iq_pc    = q_head.pc;
      iq_instr = q_head.instr;
      iq_is_c  = q_head.is_c;
    end
  end

  inst_queue #(
    .DepthW (IQ_DEPTH_W)
  ) u_inst_queue (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (q_push),
    .entry_i (q_entry),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher with an adapter model and a decoder-side scoreboard.
module tb_ins_fetcher;
  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, done, ready;
  logic [31:0] redirect, ins;
  logic        try_start, iq_valid, iq_is_c;
  logic [31:0] addr, iq_pc, iq_instr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mpc;
  int          checks = 0;
  int          errors = 0;
  localparam int Lat = 4;

  always #5 clk = ~clk;

  ins_fetcher dut (
    .clk_in                  (clk),
    .rst_in                  (rst_n),
    .rdy_in                  (rdy),
    .flush_pipline           (flush),
    .redirect_pc             (redirect),
    .try_start_insfetch_task (try_start),
    .insfetch_addr           (addr),
    .insfetch_task_done      (done),
    .insfetch_ins_full       (ins),
    .iq_valid                (iq_valid),
    .iq_ready                (ready),
    .iq_pc                   (iq_pc),
    .iq_instr                (iq_instr),
    .iq_is_c                 (iq_is_c)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h8) return 32'h00004501;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = mem_word(mpc);
      exp_q.push_back('{pc: mpc, instr: w, c: (w[1:0] != 2'b11)});
      mpc = mpc + ((w[1:0] != 2'b11) ? 32'd2 : 32'd4);
    end
  endtask

  task automatic drain_exp(input string tag);
    int n = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b0;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req(input logic want, input int bound, input string tag);
    int n = 0;
    while (try_start !== want && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'b0, try_start}, {31'b0, want});
  endtask

  // Adapter: done pulses Lat cycles into each request; a rejected pulse repeats.
  initial begin
    logic prev_req;
    int   cnt;
    done = 1'b0; ins = '0; prev_req = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done = 1'b0; cnt = 0; prev_req = 1'b0;
      end else begin
        if (done) begin
          done = 1'b0; cnt = 0;
        end else if (try_start) begin
          if (!prev_req) req_log.push_back(addr);
          cnt++;
          if (cnt == Lat) begin
            done = 1'b1;
            ins  = mem_word(addr);
          end
        end else begin
          cnt = 0;
        end
        prev_req = try_start;
      end
    end
  end

  // Decoder side: every accepted head must match the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && ready && iq_valid && !flush) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_entry observed=%h expected=none", iq_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("iq_pc", iq_pc, e.pc);
          check("iq_instr", iq_instr, e.instr);
          check("iq_is_c", {31'b0, iq_is_c}, {31'b0, e.c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc0, a0;
    logic        v0;
    int          n;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; redirect = '0; ready = 1'b0; mpc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, try_start}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_valid", {31'b0, iq_valid}, 32'd0);
    check("rst_pc", iq_pc, 32'd0);
    check("rst_instr", iq_instr, 32'd0);
    check("rst_is_c", {31'b0, iq_is_c}, 32'd0);

    // Cold start: first request the cycle after the miss is seen.
    push_exp(6);
    ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_req", {31'b0, try_start}, 32'd1);
    check("first_addr", addr, 32'h0);
    drain_exp("cold_start");
    check("req0", req_log[0], 32'h0);
    check("req1", req_log[1], 32'h4);
    check("req2", req_log[2], 32'h8);
    check("req3_after_c", req_log[3], 32'hA);

    // Queue full with the decoder stalled: fetching stops.
    repeat (60) @(posedge clk);
    #1;
    check("full_valid", {31'b0, iq_valid}, 32'd1);
    check("full_no_req", {31'b0, try_start}, 32'd0);
    check("full_head", iq_pc, mpc);
    n = req_log.size();
    repeat (20) @(posedge clk);
    #1;
    check("full_req_count", 32'(req_log.size()), 32'(n));
    push_exp(6);
    drain_exp("full_drain");

    // Redirect to 0x20, then flush to 0x100 while that miss is outstanding.
    repeat (60) @(posedge clk);
    #1;
    flush = 1'b1; redirect = 32'h20;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_req(1'b1, 10, "miss20_req");
    check("miss20_addr", addr, 32'h20);
    flush = 1'b1; redirect = 32'h100;
    @(posedge clk); #1;
    flush = 1'b0;
    check("drain_req", {31'b0, try_start}, 32'd1);
    check("drain_addr", addr, 32'h20);
    wait_req(1'b0, 20, "drain_done");
    check("drain_no_enq", {31'b0, iq_valid}, 32'd0);
    wait_req(1'b1, 20, "redirect_req");
    check("redirect_addr", addr, 32'h100);
    mpc = 32'h100;
    push_exp(3);
    drain_exp("redirect_run");

    // rdy_in low freezes everything, including a done pulse and a ready decoder.
    n = 0;
    while (!(iq_valid && try_start) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_stall", {31'b0, iq_valid && try_start}, 32'd1);
    rdy = 1'b0; ready = 1'b1;
    pc0 = iq_pc; a0 = addr; v0 = iq_valid;
    repeat (12) @(posedge clk);
    #1;
    check("stall_req", {31'b0, try_start}, 32'd1);
    check("stall_addr", addr, a0);
    check("stall_head", iq_pc, pc0);
    check("stall_valid", {31'b0, iq_valid}, {31'b0, v0});
    rdy = 1'b1; ready = 1'b0;
    push_exp(3);
    drain_exp("stall_resume");

    // Asynchronous reset in the middle of a miss.
    wait_req(1'b1, 40, "pre_reset_req");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, try_start}, 32'd0);
    check("async_rst_valid", {31'b0, iq_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mpc = 32'h0;
    wait_req(1'b1, 10, "post_rst_req");
    check("post_rst_addr", addr, 32'h0);

`ifdef ICACHE_EN
    // Second pass over cached code: no requests, one instruction per cycle.
    repeat (60) @(posedge clk);
    #1;
    flush = 1'b1; redirect = 32'h0; ready = 1'b1;
    push_exp(4);
    n = req_log.size();
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hit_no_req", 32'(req_log.size()), 32'(n));
    @(posedge clk); #1;
    check("hit_rate", 32'(exp_q.size()), 32'd0);
    ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_fetcher.md
# ins_fetcher

Instruction fetch front end sitting directly upstream of the memory adapter's instruction-fetch port. It owns the fetch PC and a direct-mapped instruction cache. On a miss it issues a fetch task to the memory adapter. Instructions are pushed, with their PC and compressed flag, into a small in-order queue drained by the decoder. Pipeline flushes redirect the PC, and any adapter task already in flight is drained safely.

## Interface
- RESET_PC, 32'h0: PC loaded at reset.
- ICACHE_IDX_W, 6: index width; the cache holds 2^ICACHE_IDX_W entries, indexed by pc[ICACHE_IDX_W:1].
- IQ_DEPTH_W, 2: the queue holds 2^IQ_DEPTH_W entries.
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; when low, all state holds.
- flush_pipline  in  1  redirect request.
- redirect_pc  in  32  new PC, valid with flush_pipline.
- try_start_insfetch_task  out  1  fetch request to the adapter; held high until done.
- insfetch_addr  out  32  fetch address; stable while the request is high.
- insfetch_task_done  in  1  single-cycle completion pulse; data is valid in the same cycle.
- insfetch_ins_full  in  32  fetched instruction; upper 16 bits are zero if compressed.
- iq_valid  out  1  queue head valid.
- iq_ready  in  1  decoder accepts the head.
- iq_pc  out  32  PC of the head instruction.
- iq_instr  out  32  head instruction.
- iq_is_c  out  1  head is compressed (instr[1:0] != 2'b11).

## Operation
- State machine with three states:
  - FETCH:
    - Cache lookup on pc, combinational: hit = valid[idx] && tag[idx] == pc[31:ICACHE_IDX_W+1].
    - Hit with the queue not full: enqueue {pc, data, is_c}; pc += is_c ? 2 : 4.
    - Miss with the queue not full: latch miss_pc = pc, go to MISS.
    - Queue full: hold.
  - MISS:
    - try_start_insfetch_task = 1, insfetch_addr = miss_pc.
    - On insfetch_task_done: write the cache entry (valid, tag, data), enqueue, advance pc by 2 or 4 from the fetched instr[1:0], return to FETCH.
    - Queue space is guaranteed, because MISS is entered only with the queue not full and only the decoder removes entries.
  - DRAIN:
    - Entered when a flush arrives during MISS with no done in that cycle.
    - The request stays high with the same address.
    - On done: cache fill still performed, no enqueue; go to FETCH at the latched redirect PC.
- Flush priority:
  - flush_pipline overrides every enqueue and dequeue in its cycle.
  - The queue is emptied, pc <= redirect_pc, and new_pc is latched.
  - A flush in DRAIN updates the latched target only.
- Flush and done in the same MISS cycle: the fill happens, no enqueue, go to FETCH at redirect_pc.
- The PC is halfword-aligned; pc[0] is ignored. PC arithmetic wraps modulo 2^32.
- The queue is a circular FIFO with read/write pointers one bit wider than the index. Full: MSBs differ and the rest are equal. Simultaneous push and pop when full are not possible, since no push occurs while full.

## Timing
- Reset values:
  - try_start_insfetch_task = 0, insfetch_addr = 0.
  - iq_valid = 0, iq_pc = 0, iq_instr = 0, iq_is_c = 0.
  - State = FETCH, pc = RESET_PC, every cache valid bit = 0, queue empty.
- Hit path: enqueue at the lookup edge; iq_valid rises the following cycle. Sustained throughput is 1 instruction per cycle.
- Miss path:
  - The request rises the cycle after FETCH detects the miss.
  - Enqueue happens at the done edge; iq_valid is high the next cycle.
  - FETCH resumes the cycle after done.
- Dequeue: when iq_valid && iq_ready, the head pops at the edge; queue outputs are registered or a direct RAM read of the head.
- rdy_in low: no state, pointer, or cache change. The request output holds its value.

## Configuration
- ICACHE_EN defined: cache storage and lookup are present, as described above.
- ICACHE_EN undefined:
  - No cache arrays; every FETCH goes to MISS when the queue is not full.
  - Cache fills are omitted; all other behaviour is unchanged.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH, MISS, DRAIN}.
  - The iq_entry_t struct {pc[31:0], instr[31:0], is_c}.
  - The is_compressed function.
- Sub-module inst_queue: parameterised FIFO of iq_entry_t with push/pop/flush/full/empty.

## Test plan
- Cold start with RESET_PC = 0 and the adapter returning 32'h00500093 after 4 cycles: one request at addr 0; queue receives {pc 0, instr 32'h00500093, is_c 0}; next request at addr 4.
- Compressed instruction 32'h00004501 at pc 8: iq_is_c = 1; next fetch at pc 10.
- Loop of 3 instructions executed twice (ICACHE_EN defined): the second pass issues no requests, and 1 instruction is enqueued per cycle.
- Flush to 32'h100 during MISS at addr 0x20: the request stays at 0x20 until done. Nothing is enqueued for 0x20, the queue is empty, and the next request is at 0x100. A later fetch of 0x20 hits.
- Queue full with iq_ready = 0: no request is issued and pc holds. Raising iq_ready drains in order and fetch resumes.
- Reset asserted mid-MISS: try_start drops immediately (asynchronously), iq_valid = 0, and all cache entries are invalid afterwards.
